// File: rtl/fpu_pkg.sv
// Shared FP32 field constants, FCLASS bit positions and the unpacked-operand record
// used by fp_unpack and its consumers.
package fpu_pkg;

  localparam int FCLASS_NEG_INF  = 0;
  localparam int FCLASS_NEG_NORM = 1;
  localparam int FCLASS_NEG_SUB  = 2;
  localparam int FCLASS_NEG_ZERO = 3;
  localparam int FCLASS_POS_ZERO = 4;
  localparam int FCLASS_POS_SUB  = 5;
  localparam int FCLASS_POS_NORM = 6;
  localparam int FCLASS_POS_INF  = 7;
  localparam int FCLASS_SNAN     = 8;
  localparam int FCLASS_QNAN     = 9;

  localparam int FP32_BIAS     = 127;
  localparam int FP32_EMAX_EXP = 255;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] sig;
    logic [9:0]  fclass;
    logic        exception;
  } fp_unpacked_t;

  // One-hot FCLASS mask of a raw FP32 word (subnormals reported as subnormal).
  function automatic logic [9:0] fp32_class(input logic [31:0] x);
    logic [9:0] c;
    c = '0;
    if (x[30:23] == 8'(FP32_EMAX_EXP)) begin
      if (x[22:0] == '0)  c[x[31] ? FCLASS_NEG_INF : FCLASS_POS_INF] = 1'b1;
      else if (x[22])     c[FCLASS_QNAN] = 1'b1;
      else                c[FCLASS_SNAN] = 1'b1;
    end else if (x[30:23] == '0) begin
      if (x[22:0] == '0)  c[x[31] ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
      else                c[x[31] ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
    end else begin
      c[x[31] ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/lzc23.sv
// Combinational leading-zero counter for a 23-bit mantissa; all-zero input gives 23.
module lzc23 (
  input  logic [22:0] i_m,
  output logic [4:0]  o_cnt
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = 5'd23;
    for (int i = 0; i < 23; i++) begin
      if (i_m[i]) o_cnt = 5'(22 - i);
    end
  end

endmodule

// File: rtl/fp_unpack.sv
// Two-stage FP32 unpack/classify pipeline with valid/ready handshake.
// Define FP_UNPACK_FTZ_EN to flush subnormal operands to signed zero.
module fp_unpack
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [9:0]  exp,
  output logic [23:0] sig,
  output logic [9:0]  fclass,
  output logic        exception
);

  logic         r_s1_valid;
  logic [31:0]  r_s1_x;
  logic [9:0]   r_s1_class;
  logic         r_s2_valid;
  fp_unpacked_t r_s2;
  fp_unpacked_t w_s2_next;
  logic [9:0]   w_class;
  logic         w_load1;
  logic         w_load2;
  logic [7:0]   w_e;
  logic [22:0]  w_m;

  assign w_load2  = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready = !r_s1_valid || w_load2;
  assign w_load1  = in_valid && in_ready;

  always_comb begin
    w_class = fp32_class(x);
`ifdef FP_UNPACK_FTZ_EN
    if (w_class[FCLASS_NEG_SUB] || w_class[FCLASS_POS_SUB]) begin
      w_class = '0;
      w_class[x[31] ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_class <= '0;
    end else if (w_load1) begin
      r_s1_valid <= 1'b1;
      r_s1_x     <= x;
      r_s1_class <= w_class;
    end else if (w_load2) begin
      r_s1_valid <= 1'b0;
    end
  end

`ifndef FP_UNPACK_FTZ_EN
  logic [4:0] w_lzc;
  logic [4:0] r_s1_lzc;

  lzc23 u_lzc (
    .i_m   (x[22:0]),
    .o_cnt (w_lzc)
  );

  always_ff @(posedge clk) begin
    if (rst)          r_s1_lzc <= '0;
    else if (w_load1) r_s1_lzc <= w_lzc;
  end
`endif

  assign w_e = r_s1_x[30:23];
  assign w_m = r_s1_x[22:0];

  // Zero (and flushed subnormals) fall through to the all-zero default.
  always_comb begin
    w_s2_next           = '0;
    w_s2_next.sign      = r_s1_x[31];
    w_s2_next.fclass    = r_s1_class;
    w_s2_next.exception = r_s1_class[FCLASS_SNAN];
    if (w_e == 8'(FP32_EMAX_EXP)) begin
      w_s2_next.exp = 10'd128;
      w_s2_next.sig = {1'b1, w_m};
    end else if (w_e != 8'd0) begin
      w_s2_next.exp = {2'b00, w_e} - 10'(FP32_BIAS);
      w_s2_next.sig = {1'b1, w_m};
    end
`ifndef FP_UNPACK_FTZ_EN
    else if (w_m != '0) begin
      w_s2_next.exp = 10'(-FP32_BIAS) - {5'b00000, r_s1_lzc};
      w_s2_next.sig = {w_m, 1'b0} << r_s1_lzc;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_load2) begin
      r_s2_valid <= 1'b1;
      r_s2       <= w_s2_next;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign sign      = r_s2.sign;
  assign exp       = r_s2.exp;
  assign sig       = r_s2.sig;
  assign fclass    = r_s2.fclass;
  assign exception = r_s2.exception;

endmodule

// File: tb/tb_fp_unpack.sv
// Scoreboard bench for fp_unpack: directed vectors, stall/reset scenarios and
// randomized operands checked against an arithmetic reference model.
module tb_fp_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign;
  logic [9:0]  exp;
  logic [23:0] sig;
  logic [9:0]  fclass;
  logic        exception;

  int total = 0;
  int bad   = 0;
  logic [45:0] sbq[$];
  bit          stall_prev = 0;
  logic [45:0] held;
  bit          rnd_done = 0;

  fp_unpack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .exp(exp),
    .sig(sig), .fclass(fclass), .exception(exception)
  );

  always #5 clk = ~clk;

  function automatic logic [45:0] pk(input logic s, input logic [9:0] e,
                                     input logic [23:0] g, input logic [9:0] c,
                                     input logic ex);
    return {s, e, g, c, ex};
  endfunction

  // Reference: value-level decode; subnormals normalized by repeated doubling.
  function automatic logic [45:0] model(input logic [31:0] v);
    int s, e, m, ex, sg, cls;
    s = int'(v[31]); e = int'(v[30:23]); m = int'(v[22:0]);
    if (e == 255) begin
      ex = 128; sg = m + (1 << 23);
      cls = (m == 0) ? (s ? 0 : 7) : ((m >= (1 << 22)) ? 9 : 8);
    end else if (e == 0 && m == 0) begin
      ex = 0; sg = 0; cls = s ? 3 : 4;
    end else if (e == 0) begin
`ifdef FP_UNPACK_FTZ_EN
      ex = 0; sg = 0; cls = s ? 3 : 4;
`else
      sg = m; ex = -126;
      while (sg < (1 << 23)) begin sg = sg * 2; ex = ex - 1; end
      cls = s ? 2 : 5;
`endif
    end else begin
      ex = e - 127; sg = m + (1 << 23); cls = s ? 1 : 6;
    end
    return pk(v[31], 10'(ex), 24'(sg), 10'(1 << cls), cls == 8);
  endfunction

  function automatic logic [45:0] act();
    return {sign, exp, sig, fclass, exception};
  endfunction

  task automatic chk(input string name, input logic [45:0] got, input logic [45:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev && out_valid) chk("stall_hold", act(), held);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output got=%h", act());
        end else begin
          logic [45:0] w;
          w = sbq.pop_front();
          chk("result", act(), w);
          $display("out s=%0b exp=%h sig=%h fclass=%h exc=%0b", sign, exp, sig, fclass, exception);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = act();
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] v, input logic [45:0] e);
    int n;
    in_valid = 1'b1; x = v; n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout got=in_ready=0 want=1");
    end else begin
      sbq.push_back(e);
      $display("in  x=%h", v);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_lat(input logic [31:0] v, input logic [45:0] e);
    send(v, e);
    @(negedge clk);
    chk("latency_cycle1", 46'(out_valid), 46'(0));
    @(negedge clk);
    chk("latency_cycle2", 46'(out_valid), 46'(1));
    @(posedge clk); #1;
  endtask

  logic [31:0] dv[11];
  logic [45:0] de[11];

  initial begin
    dv[0]  = 32'h3F800000; de[0]  = pk(0, 10'h000, 24'h800000, 10'h040, 0);
    dv[1]  = 32'h00000001;
    dv[2]  = 32'hFF800000; de[2]  = pk(1, 10'h080, 24'h800000, 10'h001, 0);
    dv[3]  = 32'h80000000; de[3]  = pk(1, 10'h000, 24'h000000, 10'h008, 0);
    dv[4]  = 32'h7F800001; de[4]  = pk(0, 10'h080, 24'h800001, 10'h100, 1);
    dv[5]  = 32'h7FC00000; de[5]  = pk(0, 10'h080, 24'hC00000, 10'h200, 0);
    dv[6]  = 32'h00400000;
    dv[7]  = 32'h807FFFFF;
    dv[8]  = 32'h00800000; de[8]  = pk(0, 10'h382, 24'h800000, 10'h040, 0);
    dv[9]  = 32'h7F7FFFFF; de[9]  = pk(0, 10'h07F, 24'hFFFFFF, 10'h040, 0);
    dv[10] = 32'hFFFFFFFF; de[10] = pk(1, 10'h080, 24'hFFFFFF, 10'h200, 0);
`ifdef FP_UNPACK_FTZ_EN
    de[1] = pk(0, 10'h000, 24'h000000, 10'h010, 0);
    de[6] = pk(0, 10'h000, 24'h000000, 10'h010, 0);
    de[7] = pk(1, 10'h000, 24'h000000, 10'h008, 0);
`else
    de[1] = pk(0, 10'h36B, 24'h800000, 10'h020, 0);
    de[6] = pk(0, 10'h381, 24'h800000, 10'h020, 0);
    de[7] = pk(1, 10'h381, 24'hFFFFFE, 10'h004, 0);
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 46'(out_valid), 46'(0));
    chk("reset_in_ready", 46'(in_ready), 46'(1));
    chk("reset_data", act(), 46'(0));
    @(posedge clk); #1;

    send_lat(dv[0], de[0]);
    for (int i = 1; i < 11; i++) send(dv[i], de[i]);

    // Stall: hold out_ready low while streaming four operands.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          logic [31:0] v;
          v = 32'h40000000 + 32'(i * 32'h00100000);
          send(v, model(v));
        end
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("stall_in_ready_full", 46'(in_ready), 46'(0));
        repeat (4) @(negedge clk);
        chk("stall_in_ready_held", 46'(in_ready), 46'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("stall_drained", 46'(sbq.size()), 46'(0));

    // Reset with two operands in flight.
    send(32'h41200000, model(32'h41200000));
    send(32'hC0400000, model(32'hC0400000));
    rst = 1'b1; in_valid = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 46'(out_valid), 46'(0));
    chk("midrst_in_ready", 46'(in_ready), 46'(1));
    @(posedge clk); #1;
    send_lat(32'h00000300, model(32'h00000300));

    // Randomized operands with random output backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] v;
          logic [22:0] m;
          logic [7:0]  e;
          m = 23'($urandom);
          e = 8'($urandom_range(1, 254));
          case ($urandom_range(0, 5))
            0: begin e = 8'd0; m = m >> $urandom_range(0, 22); end
            1: begin e = 8'd255; if ($urandom_range(0, 2) == 0) m = '0; end
            2: begin e = 8'd0; m = '0; end
            default: ;
          endcase
          v = {1'($urandom), e, m};
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(v, model(v));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;

    for (int n = 0; n < 100 && sbq.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", 46'(sbq.size()), 46'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_unpack.md
Name: fp_unpack

Overview:
- Pipelined FP32 decoder/classifier in the FPU cluster; the inverse of the sign/exponent/mantissa packing done by the sign-injection and result-assembly paths.
- Takes one IEEE-754 single per transaction and returns its fields: sign, unbiased exponent, and normalized 24-bit significand.
- Subnormals are pre-normalized.
- Also returns the RISC-V FCLASS 10-bit class mask and an invalid flag for signaling NaN.
- Consumed by FCLASS execution and by multi-cycle FPU units (div/sqrt) that need normalized operands.

Parameters:
- None. Format is fixed to FP32.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept operand this cycle
- x  input  32  FP32 operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sign  output  1  x[31]
- exp  output  10  signed unbiased exponent (two's complement)
- sig  output  24  significand, leading one at bit 23 for finite nonzero
- fclass  output  10  one-hot RISC-V class mask
- exception  output  1  high iff operand is signaling NaN

Behaviour:
- Reset: clock is clk; reset rst is synchronous and active-high. On reset, both stage valid bits clear, so out_valid=0. All data outputs reset to 0.
- Pipeline structure: two stages, S1 and S2.
  - S1 registers x, the class decode, and lzc = leading-zero count of m[22:0] (0..22).
  - S2 registers the normalize shift result. Outputs are driven directly from S2 registers.
- Latency and throughput: latency is exactly 2 cycles from the in_valid&&in_ready edge to out_valid when unstalled. Throughput is 1/cycle.
- Handshake:
  - load2 = S1.valid && (!S2.valid || out_ready).
  - in_ready = !S1.valid || load2. in_ready is combinational from state and out_ready; it does not depend on in_valid.
  - A transfer occurs on an edge where valid&&ready.
  - S2 holds all outputs stable while out_valid && !out_ready.
- Field decode (e = x[30:23], m = x[22:0]):
  - normal (e in 1..254): exp = e-127, range -126..127; sig = {1,m}.
  - subnormal (e=0, m!=0): exp = -127-lzc, range -127..-149; sig = {m,1'b0} << lzc.
  - zero: exp = 0, sig = 0.
  - inf/NaN (e=255): exp = +128; sig = {1,m}.
- fclass bit mapping:
  - 0: -inf. 1: -normal. 2: -subnormal. 3: -0.
  - 4: +0. 5: +subnormal. 6: +normal. 7: +inf.
  - 8: sNaN (e=255, m!=0, m[22]=0).
  - 9: qNaN (e=255, m[22]=1).
  - Exactly one bit is set for every input.
- NaN handling: NaN sign passes through unchanged. exception = fclass[8].
- Boundary conditions:
  - Simultaneous accept and emit in the same cycle is legal; there are no bubbles.
  - A full pipe with out_ready=0 gives in_ready=0.
  - rst asserted mid-transaction drops in-flight data; no output is produced for it.

Optional Feature:
- Macro: FP_UNPACK_FTZ_EN.
- Defined: subnormal inputs are treated as signed zero. fclass bit 3 or 4 is set, exp=0, sig=0. The lzc logic is not instantiated and S2 passes data through.
- Undefined: full subnormal normalization as specified above.

Decomposition:
- fpu_pkg holds:
  - FCLASS_* bit index constants.
  - FP32_BIAS=127, FP32_EMAX_EXP=255.
  - A struct type for {sign, exp, sig, fclass, exception}.
- Sub-module lzc23: combinational 23-bit leading-zero counter. Output is 5 bits; all-zero input yields 23. The all-zero case is not used for subnormals.

Test Plan:
- x=0x3F800000 with out_ready=1 → after 2 cycles: sign=0, exp=0x000, sig=0x800000, fclass=0x040, exception=0.
- x=0x00000001 → exp=0x36B (-149), sig=0x800000, fclass=0x020. With FP_UNPACK_FTZ_EN defined: exp=0, sig=0, fclass=0x010.
- x=0xFF800000 → fclass=0x001, exp=0x080. x=0x80000000 → fclass=0x008, sig=0.
- x=0x7F800001 → fclass=0x100, exception=1. x=0x7FC00000 → fclass=0x200, exception=0.
- Stream 4 operands back-to-back with out_ready low for cycles 3-6 → in_ready=0 once both stages are full; outputs stable while stalled; all 4 results delivered in order, none lost or duplicated.
- Assert rst for 1 cycle with 2 operands in flight → next cycle out_valid=0, in_ready=1; a following operand completes with 2-cycle latency.
